// File: rtl/game_pkg.sv
// game_pkg
//   Shared definitions for the Binary Land game-progress logic: the state
//   encoding of the level controller and the widths of the level and lives
//   buses.
package game_pkg;

   localparam int LVL_W   = 10;
   localparam int LIVES_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_LVL_DONE  = 3'd2,
      ST_LIFE_LOST = 3'd3,
      ST_OVER      = 3'd4,
      ST_WIN       = 3'd5
   } state_t;

endpackage

// File: rtl/edge_detect.sv
// edge_detect
//   Rising-edge detector. Registers sig every clock and flags the cycle in
//   which sig is high while its registered copy is still low.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous, active-low reset (clears the history bit)
//   sig   in  level input, synchronous to clk
//   rise  out high for the one cycle in which sig goes 0 -> 1
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sig_q <= 1'b0;
      else      sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/level_controller.sv
// level_controller
//   Game-progress FSM for Binary Land. Sits upstream of the level timer and
//   drives its lvl input; every change on lvl re-arms the timer.
//   Consumes the timer's time_out and the gameplay events, and produces the
//   current level, remaining lives and the game-phase flags.
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-low reset
//   start         in   1-cycle pulse: start / restart the game
//   goal_reached  in   1-cycle pulse: players met at the cage
//   player_hit    in   1-cycle pulse: player touched an enemy
//   time_out      in   level from the timer; only its rising edge counts
//   lvl           out  current level, 1..MAX_LVL
//   lives         out  remaining lives
//   playing       out  high only in PLAY
//   respawn       out  1-cycle pulse when a level (re)starts
//   game_over     out  high in OVER
//   game_won      out  high in WIN
module level_controller
   import game_pkg::*;
#(
   parameter int INIT_LIVES   = 3,
   parameter int MAX_LVL      = 10,
   parameter int PAUSE_CYCLES = 100_000_000,
   parameter int PAUSE_W      = 27
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               goal_reached,
   input  logic               player_hit,
   input  logic               time_out,
   output logic [LVL_W-1:0]   lvl,
   output logic [LIVES_W-1:0] lives,
   output logic               playing,
   output logic               respawn,
   output logic               game_over,
   output logic               game_won
);

   localparam logic [LVL_W-1:0]   LVL_FIRST  = LVL_W'(1);
   localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(MAX_LVL);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
   localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [LVL_W-1:0]     lvl_d;
   logic [LIVES_W-1:0]   lives_d;
   logic [PAUSE_W-1:0]   cnt_q, cnt_d;
   logic                 respawn_d;
   logic                 tmo_rise;
   logic                 pause_done;

   // A timeout held high for many cycles must cost only one life.
   edge_detect u_tmo_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (time_out),
      .rise (tmo_rise)
   );

   // The counter stops at PAUSE_LAST, so the pause lasts PAUSE_CYCLES cycles
   // (a single cycle when PAUSE_CYCLES is 1).
   assign pause_done = (cnt_q == PAUSE_LAST);

   // NOTE: every always_comb output gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      lvl_d     = lvl;
      lives_d   = lives;
      cnt_d     = cnt_q;
      respawn_d = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_OVER, ST_WIN: begin
            if (start) begin
               state_d   = ST_PLAY;
               lvl_d     = LVL_FIRST;
               lives_d   = LIVES_INIT;
               respawn_d = 1'b1;
            end
         end

         ST_PLAY: begin
            // One event per cycle; lower-priority events in the same cycle
            // are dropped.
            if (goal_reached) begin
               state_d = ST_LVL_DONE;
               cnt_d   = '0;
            end else if (player_hit || tmo_rise) begin
               if (lives > LIVES_W'(1)) begin
                  lives_d = lives - LIVES_W'(1);
                  state_d = ST_LIFE_LOST;
                  cnt_d   = '0;
               end else begin
                  lives_d = '0;
                  state_d = ST_OVER;
               end
            end
         end

         ST_LVL_DONE: begin
            if (!pause_done) begin
               cnt_d = cnt_q + PAUSE_W'(1);
            end else if (lvl == LVL_LAST) begin
               state_d = ST_WIN;
            end else begin
               lvl_d     = lvl + LVL_W'(1);
               state_d   = ST_PLAY;
               respawn_d = 1'b1;
            end
         end

         ST_LIFE_LOST: begin
            if (!pause_done) begin
               cnt_d = cnt_q + PAUSE_W'(1);
            end else begin
               state_d   = ST_PLAY;
               respawn_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         lvl     <= LVL_FIRST;
         lives   <= LIVES_INIT;
         cnt_q   <= '0;
         respawn <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl     <= lvl_d;
         lives   <= lives_d;
         cnt_q   <= cnt_d;
         respawn <= respawn_d;
      end
   end

   // Phase flags are decodes of the registered state, so they move one clock
   // after their cause like every other output.
   assign playing   = (state_q == ST_PLAY);
   assign game_over = (state_q == ST_OVER);
   assign game_won  = (state_q == ST_WIN);

endmodule
